number_to_seg6: RTL and testbench

Sequential converter that turns a 20-bit unsigned binary value into six 8-bit seven-segment patterns for the six-digit 74HC595 display chain. It sits directly upstream of the six-digit display driver, whose 48-bit segment input it feeds. Conversion uses an iterative double-dabble unit that handles one bit per clock. The output holds stable between conversions, so the display refresh never sees a partial result.

---
 rtl/number_to_seg6.sv | 122 ++++++++++++
 tb/tb_number_to_seg6.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/number_to_seg6.sv
// Converts a 20-bit binary value into six seven-segment bytes using a one-bit-per-clock
// double-dabble unit. seg_data changes only on the done edge.
module number_to_seg6 #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        s_clk,
  input  logic        s_reset,
  input  logic        start,
  input  logic [19:0] value,
  input  logic        blank_lz,
  input  logic [2:0]  dp_pos,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [47:0] seg_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t      state, state_nxt;
  logic [19:0] bin_q;
  logic [23:0] bcd_q;
  logic [23:0] bcd_adj;
  logic [4:0]  cnt_q;
  logic        blank_q;
  logic [2:0]  dp_q;
  logic        ovf_q;
  logic [47:0] seg_word;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h3F;
      4'd1:    seg_of = 8'h06;
      4'd2:    seg_of = 8'h5B;
      4'd3:    seg_of = 8'h4F;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'h6D;
      4'd6:    seg_of = 8'h7D;
      4'd7:    seg_of = 8'h07;
      4'd8:    seg_of = 8'h7F;
      4'd9:    seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  always_ff @(posedge s_clk) begin
    if (!s_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == 5'd1) state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Capture / shift stage: working registers need no reset, IDLE reloads them
  always_ff @(posedge s_clk) begin
    if (state == IDLE && start) begin
      bin_q   <= value;
      blank_q <= blank_lz;
      dp_q    <= dp_pos;
      ovf_q   <= (value > 20'd999999);
      bcd_q   <= 24'h0;
      cnt_q   <= 5'd20;
    end else if (state == SHIFT) begin
      bcd_q <= {bcd_adj[22:0], bin_q[19]};
      bin_q <= {bin_q[18:0], 1'b0};
      cnt_q <= cnt_q - 5'd1;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 6; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down so the leading-zero run is known per digit
  always_comb begin
    logic       lead;
    logic       blank;
    logic       dp_on;
    logic [3:0] d;
    logic [7:0] pat;
    seg_word = 48'h0;
    lead     = 1'b1;
    dp_on    = (dp_q <= 3'd5);
    for (int k = 5; k >= 0; k--) begin
      d     = bcd_q[4*k +: 4];
      lead  = lead && (d == 4'd0);
      blank = blank_q && lead && (k != 0) && !(dp_on && (3'(k) <= dp_q));
      pat   = blank ? 8'h00 : seg_of(d);
      if (dp_on && (3'(k) == dp_q)) pat[7] = 1'b1;
      if (ovf_q) pat = 8'h40;
      seg_word[8*k +: 8] = pat;
    end
  end

  // Output stage: result registers are loaded only on the ENCODE edge
  always_ff @(posedge s_clk) begin
    if (!s_reset) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      seg_data <= {48{SEG_ACTIVE_LOW}};
    end else begin
      done <= (state == ENCODE);
      if (state == ENCODE) begin
        seg_data <= seg_word ^ {48{SEG_ACTIVE_LOW}};
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_number_to_seg6.sv
// Directed bench for number_to_seg6: vector table plus multi-cycle corner sequences,
// with an active-low instance sharing the same stimulus.
module tb_number_to_seg6;

  logic        s_clk = 1'b0;
  logic        s_reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] value = 20'd0;
  logic        blank_lz = 1'b0;
  logic [2:0]  dp_pos = 3'd7;
  logic        busy, done, overflow;
  logic [47:0] seg_data;
  logic        busy_n, done_n, overflow_n;
  logic [47:0] seg_data_n;

  number_to_seg6 #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .s_clk(s_clk), .s_reset(s_reset), .start(start), .value(value),
    .blank_lz(blank_lz), .dp_pos(dp_pos), .busy(busy), .done(done),
    .overflow(overflow), .seg_data(seg_data)
  );

  number_to_seg6 #(.SEG_ACTIVE_LOW(1'b1)) dut_n (
    .s_clk(s_clk), .s_reset(s_reset), .start(start), .value(value),
    .blank_lz(blank_lz), .dp_pos(dp_pos), .busy(busy_n), .done(done_n),
    .overflow(overflow_n), .seg_data(seg_data_n)
  );

  always #5 s_clk = ~s_clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [19:0] v;
    logic        blz;
    logic [2:0]  dp;
    logic [47:0] exp_seg;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic run_conv(input logic [19:0] v, input logic blz, input logic [2:0] dp,
                          input logic [47:0] exp_seg, input logic exp_ovf, input string tag);
    int n;
    n = 0;
    value = v; blank_lz = blz; dp_pos = dp; start = 1'b1;
    tick;
    start = 1'b0;
    value = ~v; blank_lz = ~blz; dp_pos = dp ^ 3'd1;
    check({tag, " busy_after_start"}, 48'(busy), 48'd1);
    while (!done && n < 40) begin
      tick;
      n++;
    end
    check({tag, " latency"}, 48'(n), 48'd21);
    check({tag, " busy_at_done"}, 48'(busy), 48'd0);
    check({tag, " seg_data"}, seg_data, exp_seg);
    check({tag, " overflow"}, 48'(overflow), 48'(exp_ovf));
    check({tag, " seg_data_active_low"}, seg_data_n, ~exp_seg);
    check({tag, " overflow_active_low"}, 48'(overflow_n), 48'(exp_ovf));
    tick;
    check({tag, " done_one_cycle"}, 48'(done), 48'd0);
  endtask

  initial begin
    int dones;
    int first;

    vecs[0]  = '{20'd123456,  1'b0, 3'd7, 48'h065B_4F66_6D7D, 1'b0};
    vecs[1]  = '{20'd42,      1'b1, 3'd7, 48'h0000_0000_665B, 1'b0};
    vecs[2]  = '{20'd5,       1'b1, 3'd2, 48'h0000_00BF_3F6D, 1'b0};
    vecs[3]  = '{20'd1000000, 1'b0, 3'd7, 48'h4040_4040_4040, 1'b1};
    vecs[4]  = '{20'd999999,  1'b0, 3'd7, 48'h6F6F_6F6F_6F6F, 1'b0};
    vecs[5]  = '{20'd0,       1'b1, 3'd7, 48'h0000_0000_003F, 1'b0};
    vecs[6]  = '{20'd0,       1'b0, 3'd7, 48'h3F3F_3F3F_3F3F, 1'b0};
    vecs[7]  = '{20'd1000000, 1'b1, 3'd3, 48'h4040_4040_4040, 1'b1};
    vecs[8]  = '{20'd1048575, 1'b0, 3'd0, 48'h4040_4040_4040, 1'b1};
    vecs[9]  = '{20'd907,     1'b1, 3'd0, 48'h0000_006F_3F87, 1'b0};
    vecs[10] = '{20'd100,     1'b1, 3'd5, 48'hBF3F_3F06_3F3F, 1'b0};
    vecs[11] = '{20'd120,     1'b0, 3'd6, 48'h3F3F_3F06_5B3F, 1'b0};
    vecs[12] = '{20'd5,       1'b1, 3'd4, 48'h00BF_3F3F_3F6D, 1'b0};

    s_reset = 1'b0;
    repeat (2) tick;
    s_reset = 1'b1;
    repeat (5) tick;
    check("reset busy", 48'(busy), 48'd0);
    check("reset done", 48'(done), 48'd0);
    check("reset overflow", 48'(overflow), 48'd0);
    check("reset seg_data", seg_data, 48'h0);
    check("reset seg_data_active_low", seg_data_n, 48'hFFFF_FFFF_FFFF);

    for (int i = 0; i < 13; i++) begin
      run_conv(vecs[i].v, vecs[i].blz, vecs[i].dp, vecs[i].exp_seg, vecs[i].exp_ovf,
               $sformatf("vec%0d", i));
    end

    // start pulsed again mid-conversion is ignored
    value = 20'd777; blank_lz = 1'b1; dp_pos = 3'd7; start = 1'b1;
    tick;
    start = 1'b0;
    dones = 0; first = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin value = 20'd123; start = 1'b1; end
      if (n == 6) start = 1'b0;
      tick;
      if (done) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    check("restart_ignored done_count", 48'(dones), 48'd1);
    check("restart_ignored latency", 48'(first), 48'd21);
    check("restart_ignored seg_data", seg_data, 48'h0000_0007_0707);

    // reset mid-conversion aborts
    value = 20'd123456; blank_lz = 1'b0; dp_pos = 3'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    s_reset = 1'b0;
    tick;
    s_reset = 1'b1;
    check("abort busy", 48'(busy), 48'd0);
    check("abort seg_data", seg_data, 48'h0);
    check("abort seg_data_active_low", seg_data_n, 48'hFFFF_FFFF_FFFF);
    check("abort overflow", 48'(overflow), 48'd0);
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      tick;
      if (done) dones++;
    end
    check("abort no_done", 48'(dones), 48'd0);
    run_conv(20'd42, 1'b1, 3'd7, 48'h0000_0000_665B, 1'b0, "after_abort");

    // start held high restarts right after each done
    value = 20'd5; blank_lz = 1'b0; dp_pos = 3'd7; start = 1'b1;
    dones = 0; first = 0;
    for (int n = 0; n < 50; n++) begin
      tick;
      if (done) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    check("held_start done_count", 48'(dones), 48'd2);
    check("held_start first_done", 48'(first), 48'd21);
    check("held_start seg_data", seg_data, 48'h3F3F_3F3F_3F6D);
    repeat (25) tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
